// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment display blocks.
//   - SEG_HEX_0..SEG_HEX_F : logical segment patterns {G,F,E,D,C,B,A}, 1 = lit
//   - SEG_OFF              : all segments dark
//   - seg7_state_t         : scan controller states IDLE / BLANK / SHOW
// No ports (package).
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } seg7_state_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundle between application logic and the seven-segment scan driver.
//   en        : scan enable (0 = display dark)
//   value     : 4*DIGITS hex nibbles, nibble k drives digit k
//   dp_in     : per-digit decimal point request
//   blank     : per-digit force-off request
//   seg       : segment pins {G,F,E,D,C,B,A}
//   seg_dp    : decimal point pin
//   digit_en  : digit enable pins
//   scan_wrap : one-cycle pulse when the scan returns to digit 0
// Modports: master = application side, slave = driver side.
// ---------------------------------------------------------------------------
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     blank;
    logic [6:0]            seg;
    logic                  seg_dp;
    logic [DIGITS-1:0]     digit_en;
    logic                  scan_wrap;

    modport master (
        output en, value, dp_in, blank,
        input  seg, seg_dp, digit_en, scan_wrap
    );

    modport slave (
        input  en, value, dp_in, blank,
        output seg, seg_dp, digit_en, scan_wrap
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// ---------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex nibble to seven-segment pattern (logical, 1 = lit).
//   nibble  : 4-bit hex value
//   pattern : {G,F,E,D,C,B,A}
// ---------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        case (nibble)
            4'h0: pattern = SEG_HEX_0;
            4'h1: pattern = SEG_HEX_1;
            4'h2: pattern = SEG_HEX_2;
            4'h3: pattern = SEG_HEX_3;
            4'h4: pattern = SEG_HEX_4;
            4'h5: pattern = SEG_HEX_5;
            4'h6: pattern = SEG_HEX_6;
            4'h7: pattern = SEG_HEX_7;
            4'h8: pattern = SEG_HEX_8;
            4'h9: pattern = SEG_HEX_9;
            4'hA: pattern = SEG_HEX_A;
            4'hB: pattern = SEG_HEX_B;
            4'hC: pattern = SEG_HEX_C;
            4'hD: pattern = SEG_HEX_D;
            4'hE: pattern = SEG_HEX_E;
            4'hF: pattern = SEG_HEX_F;
            default: pattern = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed seven-segment driver. One digit is lit per slot of
// SLOT = CLK_HZ/REFRESH_HZ cycles; the first BLANK_CYC cycles of every slot
// are dark to avoid ghosting. Inputs are snapshotted once per frame so a
// frame is never torn by mid-scan updates.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : seg7_scan_driver_if.slave (en, value, dp_in, blank in;
//          seg, seg_dp, digit_en, scan_wrap out, all outputs registered)
// Optional feature macro: SEG7_LEADING_ZERO_SUPPRESS_EN
//   When defined, zero digits above digit 0 with no non-zero digit above
//   them show no segments (their decimal point still shows).
// ---------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_HZ         = 48000000,
    parameter int DIGITS         = 4,
    parameter int REFRESH_HZ     = 1000,
    parameter int BLANK_CYC      = 480,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int EN_ACTIVE_LOW  = 1
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_driver_if.slave bus
);

    localparam int SLOT  = CLK_HZ / REFRESH_HZ;
    localparam int CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    // Pin-level "off" values; XOR with these maps logical (1 = lit) to pins.
    localparam logic [6:0]        SEG_PIN_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_PIN_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] EN_PIN_OFF  = (EN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // With no blank interval every slot starts directly in SHOW.
    localparam seg7_state_t SLOT_START = (BLANK_CYC == 0) ? SHOW : BLANK;

    seg7_state_t          state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [4*DIGITS-1:0]  snap_value;
    logic [DIGITS-1:0]    snap_dp;
    logic [DIGITS-1:0]    snap_blank;

    logic [3:0]           cur_nibble;
    logic [6:0]           hex_pattern;
    logic [DIGITS-1:0]    lz_mask;
    logic [DIGITS-1:0]    show_en;
    logic [6:0]           show_seg;
    logic                 show_dp;

    assign cur_nibble = snap_value[{idx, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .nibble  (cur_nibble),
        .pattern (hex_pattern)
    );

`ifdef SEG7_LEADING_ZERO_SUPPRESS_EN
    logic higher_set;

    // Walk from the most significant digit down; a digit is a leading zero
    // until some digit at or above it holds a non-zero nibble.
    always_comb begin
        higher_set = 1'b0;
        lz_mask    = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (snap_value[4*k +: 4] != 4'h0) begin
                higher_set = 1'b1;
            end
            lz_mask[k] = !higher_set;
        end
    end
`else
    assign lz_mask = '0;
`endif

    // Logical view of the digit currently selected by idx. A blanked digit
    // is fully dark; a suppressed leading zero keeps its enable so the dp
    // can still show.
    always_comb begin
        show_en  = '0;
        show_seg = SEG_OFF;
        show_dp  = 1'b0;
        if (!snap_blank[idx]) begin
            show_en[idx] = 1'b1;
            show_dp      = snap_dp[idx];
            show_seg     = lz_mask[idx] ? SEG_OFF : hex_pattern;
        end
    end

    // Scan FSM. Outputs are registered from the state held before the edge,
    // so the pins lag the state by one cycle. The counter runs across the
    // whole slot (blank part included) and only clears at the slot end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            snap_value    <= '0;
            snap_dp       <= '0;
            snap_blank    <= '0;
            bus.digit_en  <= EN_PIN_OFF;
            bus.seg       <= SEG_PIN_OFF;
            bus.seg_dp    <= DP_PIN_OFF;
            bus.scan_wrap <= 1'b0;
        end else begin
            bus.scan_wrap <= 1'b0;

            if (state == SHOW) begin
                bus.digit_en <= show_en ^ EN_PIN_OFF;
                bus.seg      <= show_seg ^ SEG_PIN_OFF;
                bus.seg_dp   <= show_dp ^ DP_PIN_OFF;
            end else begin
                bus.digit_en <= EN_PIN_OFF;
                bus.seg      <= SEG_PIN_OFF;
                bus.seg_dp   <= DP_PIN_OFF;
            end

            if (!bus.en) begin
                state <= IDLE;
                cnt   <= '0;
                idx   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= SLOT_START;
                        cnt        <= '0;
                        idx        <= '0;
                        snap_value <= bus.value;
                        snap_dp    <= bus.dp_in;
                        snap_blank <= bus.blank;
                    end
                    BLANK: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == BLANK_LAST) begin
                            state <= SHOW;
                        end
                    end
                    SHOW: begin
                        if (cnt == SLOT_LAST) begin
                            cnt   <= '0;
                            state <= SLOT_START;
                            if (idx == IDX_LAST) begin
                                // Explicit wrap keeps non-power-of-two DIGITS correct.
                                idx           <= '0;
                                snap_value    <= bus.value;
                                snap_dp       <= bus.dp_in;
                                snap_blank    <= bus.blank;
                                bus.scan_wrap <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
